// File: rtl/br_amba_axi_isolate_req_ctrl.sv
// Initiator side of the isolate_req/isolate_done 4-phase handshake. It also drives the
// downstream reset pulse after isolation and keeps a sticky timeout flag for a stalled responder.
module br_amba_axi_isolate_req_ctrl #(
  parameter int TimeoutCycles         = 1024,
  parameter int DownstreamResetCycles = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic isolate_cmd,
  output logic isolate_req,
  input  logic isolate_done,
  output logic downstream_rst,
  output logic isolated,
  output logic busy,
  output logic timeout_err,
  input  logic timeout_err_clear
);

  function automatic int clamped_clog2(input int v);
    return (v <= 1) ? 1 : $clog2(v);
  endfunction

  localparam int TW = clamped_clog2(TimeoutCycles + 1);
  localparam int RW = clamped_clog2(DownstreamResetCycles + 1);
  localparam bit TO_EN = (TimeoutCycles > 0);
  localparam logic [TW-1:0] TO_MAX   = TW'(TimeoutCycles);
  localparam logic [TW-1:0] TO_LAST  = TW'((TimeoutCycles > 0) ? TimeoutCycles - 1 : 0);
  localparam logic [RW-1:0] RST_LOAD = RW'(DownstreamResetCycles);

  typedef enum logic [1:0] {IDLE, ISOLATING, ISOLATED, DEISOLATING} state_t;

  state_t        state, state_nxt;
  logic [RW-1:0] rst_cnt, rst_cnt_nxt;
  logic [TW-1:0] to_cnt, to_cnt_nxt;
  logic          to_set;

  assign busy     = (state == ISOLATING) || (state == DEISOLATING);
  assign isolated = (state == ISOLATED) && (rst_cnt == '0);

  always_comb begin
    state_nxt   = state;
    rst_cnt_nxt = rst_cnt;
    to_cnt_nxt  = to_cnt;
    to_set      = 1'b0;
    case (state)
      IDLE:        if (isolate_cmd) state_nxt = ISOLATING;
      ISOLATING: begin
        if (isolate_done) begin
          state_nxt   = ISOLATED;
          rst_cnt_nxt = RST_LOAD;
        end
      end
      // A release request waits for the downstream reset pulse to finish.
      ISOLATED: begin
        if (rst_cnt != '0)     rst_cnt_nxt = rst_cnt - 1'b1;
        else if (!isolate_cmd) state_nxt   = DEISOLATING;
      end
      DEISOLATING: if (!isolate_done) state_nxt = IDLE;
      default:     state_nxt = IDLE;
    endcase

    // The timeout count restarts on every phase change and advances only while stuck waiting.
    if (state_nxt != state) begin
      to_cnt_nxt = '0;
    end else if (busy) begin
      to_set = TO_EN && (to_cnt == TO_LAST);
      if (to_cnt != TO_MAX) to_cnt_nxt = to_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      isolate_req    <= 1'b0;
      downstream_rst <= 1'b1;
      rst_cnt        <= '0;
      to_cnt         <= '0;
      timeout_err    <= 1'b0;
    end else begin
      state          <= state_nxt;
      isolate_req    <= (state_nxt == ISOLATING) || (state_nxt == ISOLATED);
      downstream_rst <= (state_nxt == ISOLATED) && (rst_cnt_nxt != '0);
      rst_cnt        <= rst_cnt_nxt;
      to_cnt         <= to_cnt_nxt;
      // When set and clear arrive together, the set takes priority.
      timeout_err    <= to_set | (timeout_err & ~timeout_err_clear);
    end
  end

endmodule

// File: tb/tb_br_amba_axi_isolate_req_ctrl.sv
// Bench for br_amba_axi_isolate_req_ctrl. It drives two instances (T=8/D=4 and T=0/D=0)
// and checks them against a timestamp-based phase model, using directed and random stimulus.
module tb_br_amba_axi_isolate_req_ctrl;
  localparam int TA = 8, DA = 4, TB = 0, DB = 0;

  logic clk = 1'b0, rst = 1'b1, cmd = 1'b0, clr = 1'b0;
  logic done_a = 1'b0, done_b = 1'b0;
  logic req_a, drst_a, iso_a, busy_a, err_a;
  logic req_b, drst_b, iso_b, busy_b, err_b;
  logic stall_a = 1'b0, stall_b = 1'b0;

  always #5 clk = ~clk;

  br_amba_axi_isolate_req_ctrl #(.TimeoutCycles(TA), .DownstreamResetCycles(DA)) dut_a (
    .clk(clk), .rst(rst), .isolate_cmd(cmd), .isolate_req(req_a), .isolate_done(done_a),
    .downstream_rst(drst_a), .isolated(iso_a), .busy(busy_a), .timeout_err(err_a),
    .timeout_err_clear(clr));

  br_amba_axi_isolate_req_ctrl #(.TimeoutCycles(TB), .DownstreamResetCycles(DB)) dut_b (
    .clk(clk), .rst(rst), .isolate_cmd(cmd), .isolate_req(req_b), .isolate_done(done_b),
    .downstream_rst(drst_b), .isolated(iso_b), .busy(busy_b), .timeout_err(err_b),
    .timeout_err_clear(clr));

  // Model: phase 0 idle, 1 going in, 2 held, 3 coming out. start = first cycle index of the phase.
  typedef struct {
    int ph;
    int start;
    bit err;
    bit rstd;
  } mdl_t;

  mdl_t ma = '{0, 0, 1'b0, 1'b1};
  mdl_t mb = '{0, 0, 1'b0, 1'b1};
  int   cyc = 0;
  int   total = 0, bad = 0;

  function automatic mdl_t mdl_step(input mdl_t m, input int c, input logic r, input logic cm,
                                    input logic dn, input logic cl, input int t, input int d);
    mdl_t n = m;
    bit   set_e = 1'b0;
    if (r) begin
      n.ph = 0; n.start = c + 1; n.err = 1'b0; n.rstd = 1'b1;
      return n;
    end
    n.rstd = 1'b0;
    case (m.ph)
      0: if (cm) begin n.ph = 1; n.start = c + 1; end
      1, 3: begin
        if ((m.ph == 1) ? dn : !dn) begin
          n.ph = (m.ph == 1) ? 2 : 0;
          n.start = c + 1;
        end else if (t > 0 && (c - m.start + 1) == t) begin
          set_e = 1'b1;
        end
      end
      2: if ((c - m.start) >= d && !cm) begin n.ph = 3; n.start = c + 1; end
      default: n.ph = 0;
    endcase
    if (cl) n.err = 1'b0;
    if (set_e) n.err = 1'b1;
    return n;
  endfunction

  // {req, downstream_rst, isolated, busy, timeout_err} expected in cycle c
  function automatic logic [4:0] mdl_out(input mdl_t m, input int c, input int d);
    logic [4:0] o;
    o[4] = (m.ph == 1) || (m.ph == 2);
    o[3] = m.rstd || (m.ph == 2 && (c - m.start) < d);
    o[2] = (m.ph == 2) && ((c - m.start) >= d);
    o[1] = (m.ph == 1) || (m.ph == 3);
    o[0] = m.err;
    return o;
  endfunction

  always @(posedge clk) begin
    ma  <= mdl_step(ma, cyc, rst, cmd, done_a, clr, TA, DA);
    mb  <= mdl_step(mb, cyc, rst, cmd, done_b, clr, TB, DB);
    cyc <= cyc + 1;
  end

  task automatic chk(input string nm, input logic [4:0] act, input logic [4:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Sample one time unit after the edge, then check every output of both DUTs against the model.
  task automatic tick();
    @(posedge clk);
    #1;
    chk("a {req,drst,iso,busy,err}", {req_a, drst_a, iso_a, busy_a, err_a}, mdl_out(ma, cyc, DA));
    chk("b {req,drst,iso,busy,err}", {req_b, drst_b, iso_b, busy_b, err_b}, mdl_out(mb, cyc, DB));
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic set_done(input logic v);
    done_a = v;
    done_b = v;
  endtask

  initial begin
    // reset
    ticks(2);
    chk("rst req", req_a, 1'b0);
    chk("rst drst", drst_a, 1'b1);
    chk("rst busy", busy_a, 1'b0);
    chk("rst iso", iso_a, 1'b0);
    chk("rst err", err_a, 1'b0);
    rst = 1'b0;
    tick();
    chk("drst released", drst_a, 1'b0);

    // basic isolate / release
    cmd = 1'b1;
    tick();
    chk("req up", req_a, 1'b1);
    chk("busy isolating", busy_a, 1'b1);
    chk("model req up", mdl_out(ma, cyc, DA), 5'b10010);
    ticks(3);
    set_done(1'b1);
    tick();
    chk("a pulse start", drst_a, 1'b1);
    chk("a not yet isolated", iso_a, 1'b0);
    chk("b isolated at once", iso_b, 1'b1);
    chk("b no drst", drst_b, 1'b0);
    chk("model pulse start", mdl_out(ma, cyc, DA), 5'b11000);
    ticks(3);
    chk("a pulse last", drst_a, 1'b1);
    tick();
    chk("a drst off", drst_a, 1'b0);
    chk("a isolated", iso_a, 1'b1);
    chk("model isolated", mdl_out(ma, cyc, DA), 5'b10100);
    ticks(2);
    cmd = 1'b0;
    tick();
    chk("req down", req_a, 1'b0);
    chk("busy deisolating", busy_a, 1'b1);
    chk("iso off", iso_a, 1'b0);
    ticks(2);
    set_done(1'b0);
    tick();
    chk("idle busy", busy_a, 1'b0);
    chk("idle req", req_a, 1'b0);

    // cmd glitch during ISOLATING
    cmd = 1'b1;
    tick();
    cmd = 1'b0;
    ticks(2);
    chk("glitch req held", req_a, 1'b1);
    set_done(1'b1);
    tick();
    chk("glitch pulse", drst_a, 1'b1);
    ticks(3);
    chk("glitch pulse full", drst_a, 1'b1);
    tick();
    chk("glitch iso pulse", iso_a, 1'b1);
    tick();
    chk("glitch iso drop", iso_a, 1'b0);
    chk("glitch req drop", req_a, 1'b0);
    set_done(1'b0);
    ticks(2);

    // timeout on A (T=8)
    cmd = 1'b1;
    tick();
    ticks(7);
    chk("err wait 8", err_a, 1'b0);
    tick();
    chk("err wait 9", err_a, 1'b1);
    chk("b never times out", err_b, 1'b0);
    set_done(1'b1);
    tick();
    chk("err sticky isolated", err_a, 1'b1);
    ticks(4);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("err cleared", err_a, 1'b0);

    // set/clear collision on deisolate
    clr = 1'b1;
    cmd = 1'b0;
    tick();
    chk("deiso busy", busy_a, 1'b1);
    ticks(7);
    chk("collision before", err_a, 1'b0);
    tick();
    chk("collision set wins", err_a, 1'b1);
    clr = 1'b0;
    set_done(1'b0);
    ticks(2);
    chk("err sticky idle", err_a, 1'b1);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("err cleared idle", err_a, 1'b0);

    // long stall with T=0 on B
    cmd = 1'b1;
    tick();
    done_a = 1'b1;
    ticks(5000);
    chk("b no timeout after 5000", err_b, 1'b0);
    chk("b still busy", busy_b, 1'b1);
    done_b = 1'b1;
    tick();
    cmd = 1'b0;
    ticks(2);
    set_done(1'b0);
    ticks(2);

    // reset during the downstream pulse
    cmd = 1'b1;
    tick();
    set_done(1'b1);
    ticks(2);
    chk("pre-reset pulse", drst_a, 1'b1);
    rst = 1'b1;
    set_done(1'b0);
    tick();
    chk("mid rst req", req_a, 1'b0);
    chk("mid rst drst", drst_a, 1'b1);
    chk("mid rst busy", busy_a, 1'b0);
    rst = 1'b0;
    tick();
    chk("post rst drst", drst_a, 1'b0);
    chk("post rst restart", req_a, 1'b1);
    set_done(1'b1);
    tick();
    chk("restart pulse", drst_a, 1'b1);
    ticks(4);
    chk("restart isolated", iso_a, 1'b1);
    cmd = 1'b0;
    ticks(2);
    set_done(1'b0);
    ticks(2);

    // randomized traffic with a legal but sometimes stalling responder
    for (int i = 0; i < 4000; i++) begin
      tick();
      if ($urandom_range(0, 399) == 0) begin
        rst = 1'b1;
        set_done(1'b0);
      end else begin
        rst = 1'b0;
        if ($urandom_range(0, 9) == 0) cmd = ~cmd;
        clr = ($urandom_range(0, 15) == 0);
        if ($urandom_range(0, 39) == 0) stall_a = ~stall_a;
        if ($urandom_range(0, 39) == 0) stall_b = ~stall_b;
        if (!stall_a && done_a != req_a && $urandom_range(0, 2) == 0) done_a = req_a;
        if (!stall_b && done_b != req_b && $urandom_range(0, 2) == 0) done_b = req_b;
      end
    end
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
